// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framer: state encoding, SOF default,
// checksum width and error-vector bit positions (also used by the TX framer).
package uart_frame_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StCmd     = ST_CMD,
        StLen     = ST_LEN,
        StPayload = ST_PAYLOAD,
        StChk     = ST_CHK,
        StHold    = ST_HOLD
    } frame_state_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    localparam int unsigned CHK_W = 8;

    localparam int unsigned ERR_CHK     = 0;
    localparam int unsigned ERR_LEN     = 1;
    localparam int unsigned ERR_TIMEOUT = 2;
    localparam int unsigned ERR_OVERRUN = 3;
    localparam int unsigned ERR_W       = 4;

    function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload RAM for the frame parser: synchronous write, registered read.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // No reset: contents are meaningless until a frame has been written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from the UART byte stream, holds a
// validated frame for the command handler and flags malformed traffic.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = SOF_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   i_data_in,
    input  logic                         i_data_ready,
    output logic                         o_frame_valid,
    output logic [7:0]                   o_frame_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] o_frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   i_rd_addr,
    output logic [7:0]                   o_rd_data,
    input  logic                         i_frame_ack,
    output logic                         o_err_chk,
    output logic                         o_err_len,
    output logic                         o_err_timeout,
    output logic                         o_err_overrun,
    output logic [15:0]                  o_good_count
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    frame_state_e     r_state;
    logic [7:0]       r_cmd;
    logic [LW-1:0]    r_len;
    logic [CHK_W-1:0] r_chk;
    logic [AW-1:0]    r_idx;
    logic [TW-1:0]    r_to_cnt;
    logic             r_frame_valid;
    logic [7:0]       r_frame_cmd;
    logic [LW-1:0]    r_frame_len;
    logic [ERR_W-1:0] r_err;
    logic [15:0]      r_good_count;
    logic             r_rd_ok;

    logic             w_in_frame;
    logic             w_to_hit;
    logic             w_buf_we;
    logic [7:0]       w_buf_rdata;

    assign w_in_frame = (r_state == StCmd) || (r_state == StLen) ||
                        (r_state == StPayload) || (r_state == StChk);
    // Counter is one short of the limit: the coming idle cycle reaches it.
    assign w_to_hit   = (TIMEOUT_CYCLES != 0) && (32'(r_to_cnt) == TIMEOUT_CYCLES - 1);
    assign w_buf_we   = (r_state == StPayload) && i_data_ready;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_idx),
        .i_wdata (i_data_in),
        .i_raddr (i_rd_addr),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cmd         <= '0;
            r_len         <= '0;
            r_chk         <= '0;
            r_idx         <= '0;
            r_to_cnt      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cmd   <= '0;
            r_frame_len   <= '0;
            r_err         <= '0;
            r_good_count  <= '0;
            r_rd_ok       <= 1'b0;
        end else begin
            r_err   <= '0;
            r_rd_ok <= (r_state == StHold) && (LW'(i_rd_addr) < r_frame_len);

            if (w_in_frame && !i_data_ready) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_in_frame && !i_data_ready && w_to_hit) begin
                r_err[ERR_TIMEOUT] <= 1'b1;
                r_state            <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_data_ready && i_data_in == SOF_BYTE) begin
                            r_state <= StCmd;
                        end
                    end
                    StCmd: begin
                        if (i_data_ready) begin
                            r_cmd   <= i_data_in;
                            r_chk   <= i_data_in;
                            r_state <= StLen;
                        end
                    end
                    StLen: begin
                        if (i_data_ready) begin
                            if (i_data_in > 8'(MAX_LEN)) begin
                                r_err[ERR_LEN] <= 1'b1;
                                r_state        <= StIdle;
                            end else begin
                                r_len   <= i_data_in[LW-1:0];
                                r_chk   <= chk_step(r_chk, i_data_in);
                                r_idx   <= '0;
                                r_state <= (i_data_in == 8'd0) ? StChk : StPayload;
                            end
                        end
                    end
                    StPayload: begin
                        if (i_data_ready) begin
                            r_chk <= chk_step(r_chk, i_data_in);
                            r_idx <= r_idx + 1'b1;
                            if (LW'(r_idx) == r_len - 1'b1) begin
                                r_state <= StChk;
                            end
                        end
                    end
                    StChk: begin
                        if (i_data_ready) begin
                            if (i_data_in == r_chk) begin
                                r_state       <= StHold;
                                r_frame_valid <= 1'b1;
                                r_frame_cmd   <= r_cmd;
                                r_frame_len   <= r_len;
                                r_good_count  <= r_good_count + 16'd1;
                            end else begin
                                r_err[ERR_CHK] <= 1'b1;
                                r_state        <= StIdle;
                            end
                        end
                    end
                    StHold: begin
                        // Ack takes priority; a simultaneous byte is treated as an IDLE byte.
                        if (i_frame_ack) begin
                            r_frame_valid <= 1'b0;
                            r_state <= (i_data_ready && i_data_in == SOF_BYTE) ? StCmd : StIdle;
                        end else if (i_data_ready) begin
                            r_err[ERR_OVERRUN] <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_frame_valid = r_frame_valid;
    assign o_frame_cmd   = r_frame_cmd;
    assign o_frame_len   = r_frame_len;
    assign o_rd_data     = r_rd_ok ? w_buf_rdata : 8'h00;
    assign o_err_chk     = r_err[ERR_CHK];
    assign o_err_len     = r_err[ERR_LEN];
    assign o_err_timeout = r_err[ERR_TIMEOUT];
    assign o_err_overrun = r_err[ERR_OVERRUN];
    assign o_good_count  = r_good_count;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a short (50-cycle) timeout.
module tb_uart_frame_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  i_data_in;
    logic        i_data_ready;
    logic        o_frame_valid;
    logic [7:0]  o_frame_cmd;
    logic [4:0]  o_frame_len;
    logic [3:0]  i_rd_addr;
    logic [7:0]  o_rd_data;
    logic        i_frame_ack;
    logic        o_err_chk;
    logic        o_err_len;
    logic        o_err_timeout;
    logic        o_err_overrun;
    logic [15:0] o_good_count;

    int total = 0;
    int bad   = 0;

    uart_frame_parser #(
        .MAX_LEN        (16),
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_data_in     (i_data_in),
        .i_data_ready  (i_data_ready),
        .o_frame_valid (o_frame_valid),
        .o_frame_cmd   (o_frame_cmd),
        .o_frame_len   (o_frame_len),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .i_frame_ack   (i_frame_ack),
        .o_err_chk     (o_err_chk),
        .o_err_len     (o_err_len),
        .o_err_timeout (o_err_timeout),
        .o_err_overrun (o_err_overrun),
        .o_good_count  (o_good_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte; returns #1 after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        i_data_in    = b;
        i_data_ready = 1'b1;
        @(posedge clk);
        #1;
        i_data_ready = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_frame();
        i_frame_ack = 1'b1;
        @(posedge clk);
        #1;
        i_frame_ack = 1'b0;
    endtask

    function automatic logic [3:0] err_vec();
        return {o_err_overrun, o_err_timeout, o_err_len, o_err_chk};
    endfunction

    initial begin : stim
        logic seen;
        rst          = 1'b1;
        i_data_in    = 8'h00;
        i_data_ready = 1'b0;
        i_rd_addr    = 4'd0;
        i_frame_ack  = 1'b0;
        repeat (3) idle_cycle();

        check("reset_valid", 32'(o_frame_valid), 32'd0);
        check("reset_errs",  32'(err_vec()), 32'd0);
        check("reset_good",  32'(o_good_count), 32'd0);
        check("reset_rd",    32'(o_rd_data), 32'd0);
        rst = 1'b0;
        idle_cycle();

        // Good frame
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        check("good_valid_before_chk", 32'(o_frame_valid), 32'd0);
        send_byte(8'h65);
        check("good_valid", 32'(o_frame_valid), 32'd1);
        check("good_cmd",   32'(o_frame_cmd), 32'h10);
        check("good_len",   32'(o_frame_len), 32'd2);
        check("good_count1", 32'(o_good_count), 32'd1);
        i_rd_addr = 4'd0; idle_cycle();
        check("rd0", 32'(o_rd_data), 32'h33);
        i_rd_addr = 4'd1; idle_cycle();
        check("rd1", 32'(o_rd_data), 32'h44);
        i_rd_addr = 4'd2; idle_cycle();
        check("rd_beyond_len", 32'(o_rd_data), 32'h00);
        ack_frame();
        check("ack_drop_valid", 32'(o_frame_valid), 32'd0);
        i_rd_addr = 4'd0; idle_cycle();
        check("rd_after_ack", 32'(o_rd_data), 32'h00);

        // Bad checksum then good frame
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h66);
        check("badchk_pulse", 32'(err_vec()), 32'b0001);
        check("badchk_valid", 32'(o_frame_valid), 32'd0);
        idle_cycle();
        check("badchk_pulse_end", 32'(err_vec()), 32'd0);
        check("badchk_count", 32'(o_good_count), 32'd1);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h65);
        check("after_bad_valid", 32'(o_frame_valid), 32'd1);
        check("after_bad_count", 32'(o_good_count), 32'd2);
        ack_frame();

        // Zero length frame
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        check("zlen_valid", 32'(o_frame_valid), 32'd1);
        check("zlen_len",   32'(o_frame_len), 32'd0);
        check("zlen_cmd",   32'(o_frame_cmd), 32'h07);
        check("zlen_count", 32'(o_good_count), 32'd3);
        i_rd_addr = 4'd0; idle_cycle(); idle_cycle();
        check("zlen_rd", 32'(o_rd_data), 32'h00);
        ack_frame();

        // Oversize length, then garbage in IDLE
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11);
        check("oversize_pulse", 32'(err_vec()), 32'b0010);
        send_byte(8'h3C);
        check("garbage1_errs", 32'(err_vec()), 32'd0);
        send_byte(8'h5A);
        check("garbage2_errs", 32'(err_vec()), 32'd0);
        check("garbage_valid", 32'(o_frame_valid), 32'd0);

        // Timeout: pulse exactly 50 cycles after the CMD strobe
        send_byte(8'hA5); send_byte(8'h10);
        seen = 1'b0;
        for (int k = 1; k < 50; k++) begin
            idle_cycle();
            if (o_err_timeout) seen = 1'b1;
        end
        check("timeout_early", 32'(seen), 32'd0);
        idle_cycle();
        check("timeout_pulse", 32'(err_vec()), 32'b0100);
        idle_cycle();
        check("timeout_pulse_end", 32'(err_vec()), 32'd0);

        // Byte at cycle 49 keeps the frame alive
        send_byte(8'hA5); send_byte(8'h10);
        seen = 1'b0;
        for (int k = 1; k < 49; k++) begin
            idle_cycle();
            if (o_err_timeout) seen = 1'b1;
        end
        send_byte(8'h02);
        if (o_err_timeout) seen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            idle_cycle();
            if (o_err_timeout) seen = 1'b1;
        end
        check("keepalive_no_timeout", 32'(seen), 32'd0);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
        check("keepalive_valid", 32'(o_frame_valid), 32'd1);
        check("keepalive_count", 32'(o_good_count), 32'd4);

        // Overrun while holding
        i_rd_addr = 4'd0; idle_cycle();
        send_byte(8'h55);
        check("overrun_pulse", 32'(err_vec()), 32'b1000);
        idle_cycle();
        check("overrun_pulse_end", 32'(err_vec()), 32'd0);
        check("overrun_rd", 32'(o_rd_data), 32'h33);
        check("overrun_valid", 32'(o_frame_valid), 32'd1);

        // Ack and SOF in the same cycle
        i_frame_ack  = 1'b1;
        i_data_in    = 8'hA5;
        i_data_ready = 1'b1;
        @(posedge clk);
        #1;
        i_frame_ack  = 1'b0;
        i_data_ready = 1'b0;
        check("race_no_overrun", 32'(err_vec()), 32'd0);
        check("race_valid_drop", 32'(o_frame_valid), 32'd0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        check("race_frame_valid", 32'(o_frame_valid), 32'd1);
        check("race_frame_cmd",   32'(o_frame_cmd), 32'h01);
        check("race_frame_count", 32'(o_good_count), 32'd5);
        ack_frame();

        // Async reset mid-payload
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(o_good_count), 32'd0);
        check("async_rst_valid", 32'(o_frame_valid), 32'd0);
        check("async_rst_errs",  32'(err_vec()), 32'd0);
        check("async_rst_rd",    32'(o_rd_data), 32'd0);
        idle_cycle();
        rst = 1'b0;
        idle_cycle();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h65);
        check("post_rst_valid", 32'(o_frame_valid), 32'd1);
        check("post_rst_count", 32'(o_good_count), 32'd1);
        i_rd_addr = 4'd1; idle_cycle();
        check("post_rst_rd1", 32'(o_rd_data), 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
